control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Parametrised multi-cycle control unit FSM. It drives the CPU control bus (instruction/data memory enables, PC increment, register load and select, ALU mode, datapath mux selects) from the current opcode and the ALU flags. It adds three things the previous single-cycle control has none of: a memory ready handshake, wait-state timeout fault detection, and a retired-instruction counter. It sits between the instruction register/ALU flags and the memories, PC and register file.

Parameters:
OPCODE_SIZE, 5, opcode width; bit 3 selects ALU mode.
LSEL_W, 3, width of load_select; encodings SEL_PC=0, SEL_IR=1, SEL_A=2, SEL_B=3, SEL_C=4.
TIMEOUT, 16, maximum wait cycles for mem_ready; 0 disables the timeout.
COUNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  1  run request
opcode  in  OPCODE_SIZE  current IR opcode
flags  in  4  ALU flags {N,C,V,Z}; Z is bit 0
dest_sel  in  LSEL_W  destination register for writeback
mem_ready  in  1  memory access-complete strobe
rd_en_im  out  1  instruction memory read
rd_en_dm  out  1  data memory read
wr_en_dm  out  1  data memory write
inc_pc  out  1  PC increment
load_reg  out  1  register load strobe
load_select  out  LSEL_W  register targeted by load_reg
alu_mode  out  1  ALU mode
mux_select_a  out  1  mux A select
mux_select_b  out  1  mux B select
busy  out  1  high whenever state is not IDLE, HALT or FAULT
halted  out  1  state is HALT
fault  out  1  state is FAULT (sticky)
instr_count  out  COUNT_W  retired instructions; wraps

Behaviour:
- Reset:
  - rst_n=0 sampled at a clk edge sets state to IDLE, clears the wait counter and instr_count, and clears latched flags.
  - All outputs are 0 in IDLE, so every output resets to 0.
  - Reset mid-operation aborts any access immediately; no completion strobe is issued.
- Outputs are decoded combinationally from the state register, opcode, flags and mem_ready.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, FAULT.
- IDLE: enable=1 moves to FETCH on the next cycle.
- FETCH:
  - rd_en_im=1 is held until mem_ready=1.
  - In the mem_ready cycle: load_reg=1, load_select=SEL_IR, inc_pc=1; next state is DECODE.
- DECODE: a single cycle with no strobes. Next state depends on opcode:
  - 0x00-0x0F (ALU): EXECUTE.
  - 0x10 LOAD / 0x11 STORE: MEM.
  - 0x12 JMP: WRITEBACK with a PC target.
  - 0x13 BEQ: WRITEBACK with a PC target if the latched Z=1, otherwise FETCH.
  - 0x14 NOP: FETCH.
  - 0x1F HALT: HALT.
  - Any other value: FAULT.
- EXECUTE:
  - alu_mode=opcode[3], mux_select_a=1, mux_select_b=1.
  - flags is latched at the end of the cycle; next state is WRITEBACK.
- MEM:
  - LOAD: rd_en_dm=1 until mem_ready, then WRITEBACK.
  - STORE: wr_en_dm=1 until mem_ready, then instruction completion.
- WRITEBACK:
  - One cycle with load_reg=1.
  - load_select=SEL_PC for JMP/BEQ, otherwise dest_sel.
  - mux_select_a=0 for LOAD, 1 for ALU ops.
- Instruction completion (end of WRITEBACK, STORE handshake, not-taken BEQ, NOP):
  - instr_count increments by 1, wrapping at 2^COUNT_W.
  - Next state is FETCH if enable=1, else IDLE.
- enable deasserted mid-instruction: the instruction finishes and the FSM then goes to IDLE.
- Wait counter:
  - Clears on entry to FETCH/MEM and increments each cycle in which mem_ready=0.
  - With TIMEOUT>0, reaching count==TIMEOUT with mem_ready still 0 moves to FAULT.
  - mem_ready=1 in the same cycle as count==TIMEOUT counts as success.
- HALT and FAULT: all strobes 0. Exit only by reset; enable is ignored.
- A mem_ready pulse in any state other than FETCH or MEM is ignored.

Decomposition:
- ctrl_pkg holds: state_t enum, the opcode constants (OP_LOAD, OP_STORE, OP_JMP, OP_BEQ, OP_NOP, OP_HALT, ALU range), the SEL_* encodings, and the flag bit indices.
- One sub-module, wait_timer: a counter with clear, increment enable, TIMEOUT parameter and an expired output.

Test Plan:
- Reset, then enable=1, ALU opcode 0x09, dest_sel=3, mem_ready=1 on the 2nd FETCH cycle. Required: FETCH, DECODE, EXECUTE (alu_mode=1), WRITEBACK (load_reg=1, load_select=3); instr_count=1; 5 cycles from FETCH entry to completion.
- LOAD 0x10 with data memory mem_ready after 3 wait cycles. Required: rd_en_dm high for exactly 4 cycles, then WRITEBACK with mux_select_a=0.
- BEQ 0x13 with Z latched 1, then with Z latched 0. Required: taken gives load_select=SEL_PC; not-taken gives FETCH directly after DECODE and no load_reg.
- TIMEOUT=4, mem_ready held 0 in FETCH. Required: FAULT after 4 wait cycles, fault=1 sticky, enable toggles ignored; rst_n=0 returns to IDLE with all outputs 0.
- Opcode 0x1F gives halted=1 with no further strobes. Opcode 0x1A gives fault=1.
- instr_count preset near wrap (COUNT_W=4, 16 NOPs). Required: reads 0 after the 16th completion. enable dropped during EXECUTE gives IDLE after WRITEBACK.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
// Opcode map, register-select codes and ALU flag bit positions.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT,
        S_FAULT
    } state_t;

    localparam int unsigned OP_ALU_LO = 'h00;
    localparam int unsigned OP_ALU_HI = 'h0F;
    localparam int unsigned OP_LOAD   = 'h10;
    localparam int unsigned OP_STORE  = 'h11;
    localparam int unsigned OP_JMP    = 'h12;
    localparam int unsigned OP_BEQ    = 'h13;
    localparam int unsigned OP_NOP    = 'h14;
    localparam int unsigned OP_HALT   = 'h1F;

    localparam int unsigned ALU_MODE_BIT = 3;

    localparam int unsigned SEL_PC = 0;
    localparam int unsigned SEL_IR = 1;
    localparam int unsigned SEL_A  = 2;
    localparam int unsigned SEL_B  = 3;
    localparam int unsigned SEL_C  = 4;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/wait_timer.sv
// Memory wait-state counter with synchronous clear and timeout detect.
// TIMEOUT of 0 never expires; the count saturates instead of wrapping.
module wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CMAX = '1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CMAX)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle CPU control FSM with memory handshake, wait-state
// timeout fault and retired-instruction counter.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPCODE_SIZE = 5,
    parameter int LSEL_W      = 3,
    parameter int TIMEOUT     = 16,
    parameter int COUNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [OPCODE_SIZE-1:0] opcode,
    input  logic [3:0]             flags,
    input  logic [LSEL_W-1:0]      dest_sel,
    input  logic                   mem_ready,
    output logic                   rd_en_im,
    output logic                   rd_en_dm,
    output logic                   wr_en_dm,
    output logic                   inc_pc,
    output logic                   load_reg,
    output logic [LSEL_W-1:0]      load_select,
    output logic                   alu_mode,
    output logic                   mux_select_a,
    output logic                   mux_select_b,
    output logic                   busy,
    output logic                   halted,
    output logic                   fault,
    output logic [COUNT_W-1:0]     instr_count
);

    state_t state_q;
    state_t state_d;
    logic [COUNT_W-1:0] instr_count_q;
    logic [COUNT_W-1:0] instr_count_d;
    logic [3:0] flags_q;
    logic [3:0] flags_d;

    logic is_alu;
    logic is_load;
    logic is_store;
    logic is_jmp;
    logic is_beq;
    logic is_nop;
    logic is_halt;
    logic complete;
    logic tmr_clr;
    logic tmr_inc;
    logic expired;
    logic unused_flags;

    assign is_alu   = opcode <= OPCODE_SIZE'(OP_ALU_HI);
    assign is_load  = opcode == OPCODE_SIZE'(OP_LOAD);
    assign is_store = opcode == OPCODE_SIZE'(OP_STORE);
    assign is_jmp   = opcode == OPCODE_SIZE'(OP_JMP);
    assign is_beq   = opcode == OPCODE_SIZE'(OP_BEQ);
    assign is_nop   = opcode == OPCODE_SIZE'(OP_NOP);
    assign is_halt  = opcode == OPCODE_SIZE'(OP_HALT);

    // Only Z steers control today; N/C/V are latched for future branches.
    assign unused_flags = ^flags_q[3:1];

    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        flags_d       = flags_q;
        complete      = 1'b0;
        rd_en_im      = 1'b0;
        rd_en_dm      = 1'b0;
        wr_en_dm      = 1'b0;
        inc_pc        = 1'b0;
        load_reg      = 1'b0;
        load_select   = '0;
        alu_mode      = 1'b0;
        mux_select_a  = 1'b0;
        mux_select_b  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                rd_en_im = 1'b1;
                if (mem_ready) begin
                    load_reg    = 1'b1;
                    load_select = LSEL_W'(SEL_IR);
                    inc_pc      = 1'b1;
                    state_d     = S_DECODE;
                end else if (expired) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (is_alu) begin
                    state_d = S_EXECUTE;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_jmp) begin
                    state_d = S_WRITEBACK;
                end else if (is_beq) begin
                    if (flags_q[FLAG_Z]) state_d = S_WRITEBACK;
                    else complete = 1'b1;
                end else if (is_nop) begin
                    complete = 1'b1;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_EXECUTE: begin
                alu_mode     = opcode[ALU_MODE_BIT];
                mux_select_a = 1'b1;
                mux_select_b = 1'b1;
                flags_d      = flags;
                state_d      = S_WRITEBACK;
            end
            S_MEM: begin
                rd_en_dm = is_load;
                wr_en_dm = !is_load;
                if (mem_ready) begin
                    if (is_load) state_d = S_WRITEBACK;
                    else complete = 1'b1;
                end else if (expired) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                load_reg     = 1'b1;
                load_select  = (is_jmp || is_beq) ? LSEL_W'(SEL_PC) : dest_sel;
                mux_select_a = is_alu;
                complete     = 1'b1;
            end
            S_HALT: begin
            end
            S_FAULT: begin
            end
        endcase

        if (complete) begin
            instr_count_d = instr_count_q + COUNT_W'(1);
            state_d       = enable ? S_FETCH : S_IDLE;
        end
    end

    assign busy        = !(state_q inside {S_IDLE, S_HALT, S_FAULT});
    assign halted      = state_q == S_HALT;
    assign fault       = state_q == S_FAULT;
    assign instr_count = instr_count_q;

    assign tmr_clr = (state_d != state_q) &&
                     ((state_d == S_FETCH) || (state_d == S_MEM));
    assign tmr_inc = ((state_q == S_FETCH) || (state_q == S_MEM)) &&
                     !mem_ready;

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            instr_count_q <= '0;
            flags_q       <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            flags_q       <= flags_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-step bench for control_sequencer (TIMEOUT=4, COUNT_W=4).
// Each step drives mem_ready, checks the output bundle, then clocks.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [4:0] opcode;
    logic [3:0] flags;
    logic [2:0] dest_sel;
    logic       mem_ready;
    logic       rd_en_im;
    logic       rd_en_dm;
    logic       wr_en_dm;
    logic       inc_pc;
    logic       load_reg;
    logic [2:0] load_select;
    logic       alu_mode;
    logic       mux_select_a;
    logic       mux_select_b;
    logic       busy;
    logic       halted;
    logic       fault;
    logic [3:0] instr_count;

    int n_assert = 0;
    int n_fail   = 0;

    // {im,dm,wr,inc, ld, sel[2:0], alu,ma,mb, busy,halt,fault}
    localparam logic [13:0] E_IDLE  = '0;
    localparam logic [13:0] E_FWAIT = {4'b1000, 1'b0, 3'd0, 3'b000, 3'b100};
    localparam logic [13:0] E_FDONE = {4'b1001, 1'b1, 3'd1, 3'b000, 3'b100};
    localparam logic [13:0] E_DEC   = {4'b0000, 1'b0, 3'd0, 3'b000, 3'b100};
    localparam logic [13:0] E_EX1   = {4'b0000, 1'b0, 3'd0, 3'b111, 3'b100};
    localparam logic [13:0] E_EX0   = {4'b0000, 1'b0, 3'd0, 3'b011, 3'b100};
    localparam logic [13:0] E_MRD   = {4'b0100, 1'b0, 3'd0, 3'b000, 3'b100};
    localparam logic [13:0] E_MWR   = {4'b0010, 1'b0, 3'd0, 3'b000, 3'b100};
    localparam logic [13:0] E_HALT  = {4'b0000, 1'b0, 3'd0, 3'b000, 3'b010};
    localparam logic [13:0] E_FAULT = {4'b0000, 1'b0, 3'd0, 3'b000, 3'b001};

    control_sequencer #(
        .OPCODE_SIZE(5),
        .LSEL_W     (3),
        .TIMEOUT    (4),
        .COUNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .opcode      (opcode),
        .flags       (flags),
        .dest_sel    (dest_sel),
        .mem_ready   (mem_ready),
        .rd_en_im    (rd_en_im),
        .rd_en_dm    (rd_en_dm),
        .wr_en_dm    (wr_en_dm),
        .inc_pc      (inc_pc),
        .load_reg    (load_reg),
        .load_select (load_select),
        .alu_mode    (alu_mode),
        .mux_select_a(mux_select_a),
        .mux_select_b(mux_select_b),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] wb(input logic [2:0] sel, input logic ma);
        return {4'b0000, 1'b1, sel, 1'b0, ma, 1'b0, 3'b100};
    endfunction

    function automatic logic [13:0] outs();
        return {rd_en_im, rd_en_dm, wr_en_dm, inc_pc, load_reg, load_select,
                alu_mode, mux_select_a, mux_select_b, busy, halted, fault};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_o(input string tag, input logic [13:0] exp);
        check(tag, 32'(outs()), 32'(exp));
    endtask

    task automatic check_c(input string tag, input logic [3:0] exp);
        check(tag, 32'(instr_count), 32'(exp));
    endtask

    task automatic st(input logic mr, input logic [13:0] exp, input string tag);
        mem_ready = mr;
        #1;
        check_o(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        opcode = '0;
        flags = '0;
        dest_sel = '0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_o("reset_outs", E_IDLE);
        check_c("reset_cnt", 4'd0);

        // ALU 0x09 with Z=1 so BEQ later sees Z latched
        enable = 1'b1; opcode = 5'h09; flags = 4'b0001; dest_sel = 3'd3;
        st(0, E_IDLE, "alu_idle");
        st(0, E_FWAIT, "alu_f0");
        st(1, E_FDONE, "alu_f1");
        st(0, E_DEC, "alu_dec");
        st(0, E_EX1, "alu_ex");
        st(0, wb(3'd3, 1'b1), "alu_wb");
        check_c("alu_cnt", 4'd1);

        // LOAD with three wait cycles
        flags = 4'b0000; opcode = 5'h10; dest_sel = 3'd2;
        st(1, E_FDONE, "ld_f");
        st(0, E_DEC, "ld_dec");
        st(0, E_MRD, "ld_m0");
        st(0, E_MRD, "ld_m1");
        st(0, E_MRD, "ld_m2");
        st(1, E_MRD, "ld_m3");
        st(0, wb(3'd2, 1'b0), "ld_wb");
        check_c("ld_cnt", 4'd2);

        // BEQ taken on latched Z=1 although flags input is now 0
        opcode = 5'h13;
        st(1, E_FDONE, "beq1_f");
        st(0, E_DEC, "beq1_dec");
        st(0, wb(3'd0, 1'b0), "beq1_wb");
        check_c("beq1_cnt", 4'd3);

        // ALU 0x01 latches Z=0
        opcode = 5'h01; dest_sel = 3'd4; flags = 4'b0000;
        st(1, E_FDONE, "alu2_f");
        st(0, E_DEC, "alu2_dec");
        st(0, E_EX0, "alu2_ex");
        st(0, wb(3'd4, 1'b1), "alu2_wb");
        check_c("alu2_cnt", 4'd4);

        // BEQ not taken: DECODE goes straight back to FETCH
        opcode = 5'h13; flags = 4'b0001;
        st(1, E_FDONE, "beq0_f");
        st(0, E_DEC, "beq0_dec");
        check_c("beq0_cnt", 4'd5);
        opcode = 5'h11;
        st(0, E_FWAIT, "beq0_nt");

        // STORE completes on the handshake
        st(1, E_FDONE, "st_f");
        st(0, E_DEC, "st_dec");
        st(1, E_MWR, "st_m");
        check_c("st_cnt", 4'd6);

        // HALT ignores enable and mem_ready
        opcode = 5'h1F;
        st(1, E_FDONE, "halt_f");
        st(0, E_DEC, "halt_dec");
        enable = 1'b0;
        st(1, E_HALT, "halt0");
        enable = 1'b1;
        st(1, E_HALT, "halt1");
        check_c("halt_cnt", 4'd6);

        do_reset();
        check_o("rst2_outs", E_IDLE);
        check_c("rst2_cnt", 4'd0);

        // mem_ready exactly at count==TIMEOUT succeeds; then bad opcode
        opcode = 5'h1A;
        st(0, E_IDLE, "edge_idle");
        st(0, E_FWAIT, "edge_w0");
        st(0, E_FWAIT, "edge_w1");
        st(0, E_FWAIT, "edge_w2");
        st(0, E_FWAIT, "edge_w3");
        st(1, E_FDONE, "edge_ok");
        st(0, E_DEC, "bad_dec");
        st(0, E_FAULT, "bad_op");

        do_reset();
        check_o("rst3_outs", E_IDLE);

        // Fetch timeout
        opcode = 5'h14;
        st(0, E_IDLE, "to_idle");
        for (int i = 0; i < 5; i++) st(0, E_FWAIT, "to_wait");
        st(0, E_FAULT, "to_fault");
        enable = 1'b0;
        st(1, E_FAULT, "to_sticky0");
        enable = 1'b1;
        st(0, E_FAULT, "to_sticky1");
        do_reset();
        check_o("rst4_outs", E_IDLE);
        check_c("rst4_cnt", 4'd0);

        // 16 NOPs wrap the 4-bit counter
        st(0, E_IDLE, "nop_idle");
        for (int i = 0; i < 16; i++) begin
            st(1, E_FDONE, "nop_f");
            st(0, E_DEC, "nop_dec");
            check_c("nop_cnt", 4'((i + 1) % 16));
        end

        // enable dropped during EXECUTE
        opcode = 5'h05; dest_sel = 3'd1;
        st(1, E_FDONE, "drop_f");
        st(0, E_DEC, "drop_dec");
        enable = 1'b0;
        st(0, E_EX0, "drop_ex");
        st(0, wb(3'd1, 1'b1), "drop_wb");
        st(0, E_IDLE, "drop_idle");
        check_c("drop_cnt", 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
